// File: rtl/up_sampler_pkg.sv
// Shared types and sizing helpers for the 2x nearest-neighbour upsampler.
package up_sampler_pkg;

  // Controller states: pass 0 fetches and emits live pixels, replay re-emits the row.
  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    EMIT0,
    EMIT1,
    RLOAD,
    REMIT0,
    REMIT1
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row pixel store: simple dual-port RAM with a registered read port.
module line_buffer
  import up_sampler_pkg::*;
#(
  parameter int DEPTH  = 320,
  parameter int DATA_W = 8,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the pixel fetched during pass 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle latency, output holds until the next read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/up_sampler.sv
// 2x nearest-neighbour upsampler: each input pixel is emitted twice, and each
// completed row is replayed from the line buffer to double it vertically.
module up_sampler
  import up_sampler_pkg::*;
#(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_empty,
  output logic              src_rd_en,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done
);

  localparam int COL_W = cnt_w(IN_WIDTH);
  localparam int ROW_W = cnt_w(IN_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic              done_nxt;
  logic              lb_wr_en, lb_rd_en;
  logic              col_last, row_last;
  logic [DATA_W-1:0] hold_p1;
  logic [DATA_W-1:0] replay_p1;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Output strobes decode directly from the state so they stay stable during stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eol   = 1'b0;
    case (state)
      EMIT0: begin
        out_valid = 1'b1;
        out_data  = hold_p1;
        out_sof   = (col == '0) && (row == '0);
      end
      EMIT1: begin
        out_valid = 1'b1;
        out_data  = hold_p1;
        out_eol   = col_last;
      end
      REMIT0: begin
        out_valid = 1'b1;
        out_data  = replay_p1;
      end
      REMIT1: begin
        out_valid = 1'b1;
        out_data  = replay_p1;
        out_eol   = col_last;
      end
      default: ;
    endcase
  end

  // Next-state, counter updates and FIFO/line-buffer strobes.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    done_nxt  = 1'b0;
    src_rd_en = 1'b0;
    lb_wr_en  = 1'b0;
    lb_rd_en  = 1'b0;
    case (state)
      FETCH: begin
        // Reading only from FETCH keeps a single read outstanding.
        if (!src_empty && !rst) begin
          src_rd_en = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (src_valid) begin
          lb_wr_en  = 1'b1;
          state_nxt = EMIT0;
        end
      end
      EMIT0: begin
        if (out_ready) state_nxt = EMIT1;
      end
      EMIT1: begin
        if (out_ready) begin
          if (col_last) begin
            col_nxt   = '0;
            state_nxt = RLOAD;
          end else begin
            col_nxt   = col + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      RLOAD: begin
        lb_rd_en  = 1'b1;
        state_nxt = REMIT0;
      end
      REMIT0: begin
        if (out_ready) state_nxt = REMIT1;
      end
      REMIT1: begin
        if (out_ready) begin
          if (col_last) begin
            col_nxt   = '0;
            row_nxt   = row_last ? '0 : row + 1'b1;
            done_nxt  = row_last;
            state_nxt = FETCH;
          end else begin
            col_nxt   = col + 1'b1;
            state_nxt = RLOAD;
          end
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Control registers: state, position counters and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      frame_done <= done_nxt;
    end
  end

  // Pass-0 hold register: captures the fetched pixel; data only, no reset.
  always_ff @(posedge clk) begin
    if (lb_wr_en) hold_p1 <= src_data;
  end

  line_buffer #(
    .DEPTH  (IN_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (col),
    .wr_data (src_data),
    .rd_en   (lb_rd_en),
    .rd_addr (col),
    .rd_data (replay_p1)
  );

endmodule

// File: tb/tb_up_sampler.sv
// Directed bench for up_sampler at 4x2 with a FIFO model and an expected-output scoreboard.
module tb_up_sampler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_empty;
  logic          src_rd_en;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];

  logic          hold_empty   = 1'b0;
  logic          spur_arm     = 1'b0;
  logic          rand_ready   = 1'b0;
  logic          ready_force  = 1'b1;
  logic          last_genuine = 1'b0;
  logic          prev_stall   = 1'b0;
  logic [DW-1:0] prev_data    = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int fd_cnt   = 0;
  int fd0      = 0;
  int n0       = 0;

  always #5 clk = ~clk;

  up_sampler #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_empty  (src_empty),
    .src_rd_en  (src_rd_en),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  assign src_empty = hold_empty || (fifo_q.size() == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: data and valid one cycle after a read; optional spurious 0xFF
  // the cycle after each genuine delivery (the DUT is in EMIT0 then).
  always @(posedge clk) begin
    src_valid    <= 1'b0;
    last_genuine <= 1'b0;
    if (src_rd_en && fifo_q.size() != 0) begin
      src_data     <= fifo_q.pop_front();
      src_valid    <= 1'b1;
      last_genuine <= 1'b1;
    end else if (spur_arm && last_genuine) begin
      src_data  <= 8'hFF;
      src_valid <= 1'b1;
    end
  end

  // Downstream ready, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Output monitor: scoreboard compare on handshake, stall stability, no reads while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && !out_ready) check("rd_while_stalled", 32'(src_rd_en), 32'd0);
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sof", 32'(out_sof), 32'(e.sof));
          check("out_eol", 32'(out_eol), 32'(e.eol));
        end
        n_out <= n_out + 1;
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  // Expected output of one frame whose input pixels are base, base+1, ...
  task automatic push_exp(input int base);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < W; c++)
          for (int k = 0; k < 2; k++) begin
            e.d   = DW'(base + r * W + c);
            e.sof = (r == 0) && (p == 0) && (c == 0) && (k == 0);
            e.eol = (c == W - 1) && (k == 1);
            exp_q.push_back(e);
          end
  endtask

  task automatic push_pix(input int v);
    fifo_q.push_back(DW'(v));
  endtask

  task automatic push_frame(input int base);
    push_exp(base);
    for (int i = 0; i < W * H; i++) push_pix(base + i);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, input int target, input int budget);
    int i = 0;
    while (n_out < target && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(n_out >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(src_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_sof"}, 32'(out_sof), 32'd0);
    check({tag, "_eol"}, 32'(out_eol), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    // Reset with pixels already waiting: nothing may be read or emitted.
    push_frame(1);
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass-0 latency: read at t, src_valid at t+1, out_valid at t+2.
    begin
      int i = 0;
      @(negedge clk);
      while (!src_rd_en && i < 20) begin
        @(negedge clk);
        i++;
      end
      check("first_rd_en", 32'(src_rd_en), 32'd1);
    end
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    check("lat_t1_src_valid", 32'(src_valid), 32'd1);
    @(negedge clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_data", 32'(out_data), 32'd1);
    wait_drain("basic_drain", 500);
    check("basic_frame_done", 32'(fd_cnt), 32'd1);

    // Random backpressure.
    fd0 = fd_cnt;
    rand_ready = 1'b1;
    push_frame(1);
    wait_drain("bp_drain", 2000);
    rand_ready = 1'b0;
    check("bp_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Empty FIFO stall after pixel 2.
    fd0 = fd_cnt;
    n0  = n_out;
    push_exp(1);
    push_pix(1);
    push_pix(2);
    wait_out("stall_reach_px2", n0 + 4, 200);
    hold_empty = 1'b1;
    for (int i = 3; i <= W * H; i++) push_pix(i);
    repeat (10) begin
      @(negedge clk);
      check("hold_rd_en", 32'(src_rd_en), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    hold_empty = 1'b0;
    wait_drain("stall_drain", 500);
    check("stall_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Spurious 0xFF on src_valid while in EMIT0 must be dropped.
    fd0 = fd_cnt;
    spur_arm = 1'b1;
    push_frame(1);
    wait_drain("spur_drain", 500);
    spur_arm = 1'b0;
    check("spur_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Reset during replay of row 0, then a clean frame.
    n0 = n_out;
    push_frame(1);
    wait_out("rst_reach_replay", n0 + 10, 300);
    rst = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fd0 = fd_cnt;
    push_frame(1);
    wait_drain("after_rst_drain", 500);
    check("after_rst_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Back-to-back frames: second frame uses pixels 9..16.
    fd0 = fd_cnt;
    push_frame(1);
    push_frame(W * H + 1);
    wait_drain("b2b_drain", 1000);
    check("b2b_frame_done", 32'(fd_cnt - fd0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_sampler.md
# up_sampler

Consumes the blurred, downsampled pixel stream from the Gaussian stage's output FIFO and reconstructs a 2x nearest-neighbour upsampled image. It drives the FIFO read side (`src_rd_en`), pulling one pixel per request. Each pixel is emitted twice horizontally, and each completed row is replayed from an internal line buffer to double it vertically. Output is a raster stream with a valid/ready handshake toward the next scale-space stage.

## Interface
- `IN_WIDTH`, default 320: pixels per input row (output row is 2*IN_WIDTH).
- `IN_HEIGHT`, default 240: input rows per frame (output frame is 2*IN_HEIGHT rows).
- `DATA_W`, default 8: pixel width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `src_empty`, in, 1: upstream FIFO empty.
- `src_rd_en`, out, 1: FIFO read request, one pixel per asserted cycle.
- `src_valid`, in, 1: FIFO read data valid, the cycle after `src_rd_en`.
- `src_data`, in, DATA_W: FIFO read data.
- `out_valid`, out, 1: output pixel valid.
- `out_ready`, in, 1: downstream accepts the pixel when high together with `out_valid`.
- `out_data`, out, DATA_W: output pixel.
- `out_sof`, out, 1: qualifies the first pixel of the output frame.
- `out_eol`, out, 1: qualifies the last pixel of each output row.
- `frame_done`, out, 1: one-cycle pulse after the final output pixel of the frame is accepted.

## Operation
- FSM states:
  - FETCH: assert `src_rd_en` iff `!src_empty`, then go to WAIT. If the FIFO is empty, stay in FETCH.
  - WAIT: on `src_valid`, latch `src_data` into the hold register and write it to `linebuf[col]`, then go to EMIT0. Without `src_valid`, remain in WAIT.
  - EMIT0 and EMIT1: present the hold register. Advance on handshake.
  - After EMIT1:
    - if col < IN_WIDTH-1: col++ and go to FETCH;
    - else: col=0 and go to RLOAD.
  - RLOAD: issue a linebuf read at col. Data is registered into the hold register, then go to REMIT0.
  - REMIT0 and REMIT1: emit the replayed pixel twice.
  - After REMIT1:
    - if col < IN_WIDTH-1: col++ and go to RLOAD;
    - else: col=0, row++ (wrap to 0 at IN_HEIGHT) and go to FETCH.
- `out_valid` is high exactly in EMIT0/1 and REMIT0/1. `out_data` holds stable while `out_valid && !out_ready`.
- `out_sof` is high in EMIT0 when col==0 and row==0.
- `out_eol` is high in EMIT1 and in REMIT1 when col==IN_WIDTH-1.
- `frame_done` fires on the REMIT1 handshake at col==IN_WIDTH-1, row==IN_HEIGHT-1.
- At most one FIFO read is outstanding. `src_valid` outside WAIT is ignored, and that data is dropped.
- Counter widths: col is $clog2(IN_WIDTH) bits, row is $clog2(IN_HEIGHT) bits. Wrap is by explicit compare, never by overflow.

## Timing
- Reset values: `src_rd_en`=0, `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eol`=0, `frame_done`=0. State=FETCH, col=0, row=0.
- Reset mid-frame aborts the frame. Linebuf contents are not cleared, because they are overwritten before replay.
- Pass-0 latency: `src_rd_en` at cycle t, `src_valid` at t+1, `out_valid` at t+2.
- Replay latency: RLOAD to `out_valid` is 1 cycle.
- Maximum rate: 4 cycles per input pixel in pass 0, 3 cycles per pixel pair in replay. This holds with `out_ready` tied high.
- Backpressure: the FSM never advances from an EMIT/REMIT state without a handshake, and no read is issued while stalled.
- Empty FIFO mid-row: stall in FETCH. No output gaps are corrupted, and col/row are unchanged.

## Structure
- Package `up_sampler_pkg`: FSM state enum (FETCH, WAIT, EMIT0, EMIT1, RLOAD, REMIT0, REMIT1) and the counter-width helper constants.
- Sub-module `line_buffer`: IN_WIDTH x DATA_W simple dual-port RAM with a registered read port and 1-cycle read latency. It is instantiated once.

## Test plan
- Reset and idle (IN_WIDTH=4, IN_HEIGHT=2): FIFO holds 8 pixels 1..8, ready always high.
  - Output is 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice.
  - `out_sof` is high on the first pixel only.
  - `out_eol` is high on output pixels 8, 16, 24 and 32.
  - `frame_done` pulses once.
- Backpressure: toggle `out_ready` randomly.
  - The output sequence is identical to the previous scenario.
  - `out_data` is stable through every stall, and `src_rd_en` never pulses while `out_valid && !out_ready`.
- Empty FIFO stall: hold `src_empty` high for 10 cycles after pixel 2.
  - No `src_rd_en` pulses occur during the hold and `out_valid` stays 0.
  - The output resumes with 3,3.
- Spurious `src_valid` in EMIT0 with data 0xFF: 0xFF never appears on `out_data`.
- Reset mid-frame: assert `rst` during replay of row 0.
  - All outputs are 0 the next cycle.
  - The next frame starts with `out_sof` on its first pixel.
- Back-to-back frames: 16 pixels at 4x2.
  - `frame_done` pulses twice.
  - The second frame's first pixel carries `out_sof`.
  - row wraps to 0.
